rbm_sram_slave: RTL and testbench

Memory-side responder on the rbm data bus: accepts one load or store request per transaction from the core's memory access unit, applies byte-lane write enables to a local word-organised SRAM array, and returns the full 32-bit word for loads with a configurable number of wait states. It sits between the core and its data RAM. The core issues the request in its first stage and consumes `rbm_data_o` in its second; lane extraction and sign extension of load data stay in the core.

---
 rtl/rbm_sram_slave_if.sv | 59 +++++
 rtl/rbm_sram_slave.sv | 220 ++++++++++++++++++++++
 tb/tb_rbm_sram_slave.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rbm_sram_slave_if.sv
// -----------------------------------------------------------------------------
// rbm_sram_slave_if
//
// Purpose : groups the rbm data-bus request/response signals exchanged between
//           the core's memory access unit (master) and the SRAM responder
//           (slave). Signal names keep the slave's point of view, so the _i
//           signals are driven by the master and the _o signals by the slave.
//
// Signals : rbm_addr_i  [ADDR_WIDTH] byte address of the request
//           rbm_data_i  [32]         store data, already lane-positioned
//           rbm_size_i  [3]          one-hot {word, half, byte}
//           rbm_we_i                 store request
//           rbm_rd_i                 load request
//           rbm_data_o  [32]         full load word, zero outside a good load ack
//           rbm_ack_o                one-cycle completion pulse
//           rbm_err_o                qualifies rbm_ack_o: request rejected
//           rbm_busy_o               slave cannot accept, master holds request
//
// ADDR_WIDTH must match the ADDR_WIDTH of the rbm_sram_slave it connects to.
// -----------------------------------------------------------------------------
interface rbm_sram_slave_if #(
  parameter int ADDR_WIDTH = 12
);

  logic [ADDR_WIDTH-1:0] rbm_addr_i;
  logic [31:0]           rbm_data_i;
  logic [2:0]            rbm_size_i;
  logic                  rbm_we_i;
  logic                  rbm_rd_i;
  logic [31:0]           rbm_data_o;
  logic                  rbm_ack_o;
  logic                  rbm_err_o;
  logic                  rbm_busy_o;

  modport slave (
    input  rbm_addr_i,
    input  rbm_data_i,
    input  rbm_size_i,
    input  rbm_we_i,
    input  rbm_rd_i,
    output rbm_data_o,
    output rbm_ack_o,
    output rbm_err_o,
    output rbm_busy_o
  );

  modport master (
    output rbm_addr_i,
    output rbm_data_i,
    output rbm_size_i,
    output rbm_we_i,
    output rbm_rd_i,
    input  rbm_data_o,
    input  rbm_ack_o,
    input  rbm_err_o,
    input  rbm_busy_o
  );

endinterface : rbm_sram_slave_if

// File: rtl/rbm_sram_slave.sv
// -----------------------------------------------------------------------------
// rbm_sram_slave
//
// Purpose : memory-side responder on the rbm data bus. Accepts one load or
//           store per transaction, applies byte-lane write enables to a local
//           word-organised SRAM, and returns the full 32-bit word for loads
//           after WAIT_CYCLES extra cycles. Lane extraction and sign extension
//           of load data are left to the core.
//
// Parameters:
//   ADDR_WIDTH  byte-address width; the array holds 2^(ADDR_WIDTH-2) words
//   WAIT_CYCLES extra cycles between accept and commit, 0..15
//
// Ports   : clk_i  clock, all state changes on the rising edge
//           rst_i  asynchronous active-high reset
//           bus    rbm_sram_slave_if.slave (request in, response out)
//
// Timing  : request accepted in cycle T -> rbm_ack_o in cycle T+1+WAIT_CYCLES
//           for one cycle; rbm_busy_o high in cycles T+1 .. T+WAIT_CYCLES.
//           Back-to-back requests are accepted in the ack cycle, giving one
//           transaction per 1+WAIT_CYCLES cycles.
// -----------------------------------------------------------------------------
module rbm_sram_slave #(
  parameter int ADDR_WIDTH  = 12,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                clk_i,
  input  logic                rst_i,
  rbm_sram_slave_if.slave     bus
);

  localparam int         DEPTH     = 1 << (ADDR_WIDTH - 2);
  localparam bit         HAS_WAIT  = (WAIT_CYCLES != 0);
  // Counter preload: the commit happens on the edge where the counter reads 0,
  // so WAIT_CYCLES-1 yields exactly WAIT_CYCLES busy cycles.
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  localparam logic [2:0] SIZE_BYTE = 3'b001;
  localparam logic [2:0] SIZE_HALF = 3'b010;
  localparam logic [2:0] SIZE_WORD = 3'b100;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // State and latched request
  // ---------------------------------------------------------------------------
  state_t                r_state;
  state_t                w_state_next;
  logic [3:0]            r_cnt;

  logic [ADDR_WIDTH-1:0] r_addr;
  logic [31:0]           r_data;
  logic [2:0]            r_size;
  logic                  r_we;
  logic                  r_rd;

  logic [31:0]           r_rdata;
  logic                  r_err;

  logic [31:0]           r_mem [DEPTH];

  // ---------------------------------------------------------------------------
  // Request selection
  //
  // With no wait states the access commits on the accept edge, so it must use
  // the live bus inputs. With wait states the commit happens later and uses
  // the copy latched at accept; the bus is not sampled while in WAIT.
  // ---------------------------------------------------------------------------
  logic                  w_req;
  logic                  w_in_wait;
  logic                  w_accept;
  logic                  w_commit;

  logic [ADDR_WIDTH-1:0] w_addr;
  logic [31:0]           w_data;
  logic [2:0]            w_size;
  logic                  w_we;
  logic                  w_rd;

  logic [ADDR_WIDTH-3:0] w_idx;
  logic [3:0]            w_be;
  logic                  w_size_ok;
  logic                  w_err;

  assign w_req     = bus.rbm_we_i | bus.rbm_rd_i;
  assign w_in_wait = (r_state == S_WAIT);
  assign w_accept  = !w_in_wait && w_req;

  assign w_addr = w_in_wait ? r_addr : bus.rbm_addr_i;
  assign w_data = w_in_wait ? r_data : bus.rbm_data_i;
  assign w_size = w_in_wait ? r_size : bus.rbm_size_i;
  assign w_we   = w_in_wait ? r_we   : bus.rbm_we_i;
  assign w_rd   = w_in_wait ? r_rd   : bus.rbm_rd_i;

  // While rst_i is high the state is held at IDLE, so a pending request can
  // never reach its commit through WAIT; the master keeps we/rd low in reset.
  assign w_commit = HAS_WAIT ? (w_in_wait && (r_cnt == 4'd0)) : w_accept;

  assign w_idx = w_addr[ADDR_WIDTH-1:2];

  // ---------------------------------------------------------------------------
  // Request checking and byte enables
  // ---------------------------------------------------------------------------
  assign w_size_ok = (w_size == SIZE_BYTE) || (w_size == SIZE_HALF) ||
                     (w_size == SIZE_WORD);

  assign w_err = !w_size_ok ||
                 (w_we && w_rd) ||
                 ((w_size == SIZE_HALF) && w_addr[0]) ||
                 ((w_size == SIZE_WORD) && (w_addr[1:0] != 2'b00));

  always_comb begin
    // NOTE: every variable written in a combinational block gets a default
    // first; otherwise a size outside the case items would infer a latch.
    w_be = 4'b0000;
    case (w_size)
      SIZE_BYTE: w_be = 4'b0001 << w_addr[1:0];
      SIZE_HALF: w_be = w_addr[1] ? 4'b1100 : 4'b0011;
      SIZE_WORD: w_be = 4'b1111;
      default:   w_be = 4'b0000;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE, S_RESP: begin
        // RESP accepts like IDLE so back-to-back requests see no bubble.
        if (w_req) begin
          w_state_next = HAS_WAIT ? S_WAIT : S_RESP;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      S_WAIT: begin
        if (r_cnt == 4'd0) begin
          w_state_next = S_RESP;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State, counter, request latch and response registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst_i) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_addr  <= '0;
      r_data  <= '0;
      r_size  <= '0;
      r_we    <= 1'b0;
      r_rd    <= 1'b0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_next;

      if (w_accept) begin
        r_addr <= bus.rbm_addr_i;
        r_data <= bus.rbm_data_i;
        r_size <= bus.rbm_size_i;
        r_we   <= bus.rbm_we_i;
        r_rd   <= bus.rbm_rd_i;
      end

      if (w_accept && HAS_WAIT) begin
        r_cnt <= WAIT_LOAD;
      end else if (w_in_wait && (r_cnt != 4'd0)) begin
        r_cnt <= r_cnt - 4'd1;
      end

      // Response registers are loaded only on the commit edge and cleared on
      // every other edge, which keeps rbm_data_o/rbm_err_o zero outside the
      // ack cycle without any gating logic on the outputs.
      if (w_commit) begin
        r_err   <= w_err;
        r_rdata <= (w_rd && !w_err) ? r_mem[w_idx] : 32'h0;
      end else begin
        r_err   <= 1'b0;
        r_rdata <= 32'h0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // SRAM array
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    // NOTE: the array has no reset so it maps onto a RAM macro; its contents
    // are undefined after power-up.
    if (w_commit && w_we && !w_err) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) begin
          r_mem[w_idx][8*i +: 8] <= w_data[8*i +: 8];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: registers and state only, no combinational path from the bus
  // ---------------------------------------------------------------------------
  assign bus.rbm_data_o = r_rdata;
  assign bus.rbm_err_o  = r_err;
  assign bus.rbm_ack_o  = (r_state == S_RESP);
  assign bus.rbm_busy_o = (r_state == S_WAIT);

endmodule : rbm_sram_slave

// File: tb/tb_rbm_sram_slave.sv
// -----------------------------------------------------------------------------
// tb_rbm_sram_slave
//
// Two slaves share the clock: dut0 with no wait states and dut1 with three.
// A byte-addressed memory model and a list of issued transactions predict the
// ack/err/busy/data of each slave on every cycle; literal values pin the
// model on the key loads.
// -----------------------------------------------------------------------------
module tb_rbm_sram_slave;

  localparam int         AW     = 12;
  localparam int         W0     = 0;
  localparam int         W1     = 3;
  localparam logic [2:0] SZ_B   = 3'b001;
  localparam logic [2:0] SZ_H   = 3'b010;
  localparam logic [2:0] SZ_W   = 3'b100;

  logic clk = 1'b0;
  logic rst0;
  logic rst1;

  always #5 clk = ~clk;

  rbm_sram_slave_if #(.ADDR_WIDTH(AW)) bus0 ();
  rbm_sram_slave_if #(.ADDR_WIDTH(AW)) bus1 ();

  rbm_sram_slave #(.ADDR_WIDTH(AW), .WAIT_CYCLES(W0)) dut0 (
    .clk_i (clk),
    .rst_i (rst0),
    .bus   (bus0)
  );

  rbm_sram_slave #(.ADDR_WIDTH(AW), .WAIT_CYCLES(W1)) dut1 (
    .clk_i (clk),
    .rst_i (rst1),
    .bus   (bus1)
  );

  // Issued transaction as the model sees it.
  typedef struct {
    int              dut;
    int              t_acc;
    int              t_ack;
    logic [AW-1:0]   addr;
    logic [31:0]     data;
    logic [2:0]      size;
    logic            we;
    logic            rd;
  } ev_t;

  ev_t         ev_q[$];
  logic [7:0]  mem_b [2][1 << AW];
  int          cyc = 0;
  int          free_c [2];
  int          n_err = 0;
  int          n_checks = 0;
  logic        cmp_en = 1'b0;
  logic [31:0] last_exp [2];
  logic [31:0] last_act [2];
  logic        last_err_exp [2];
  logic        last_err_act [2];
  int          ack_cnt [2];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int wait_of(input int k);
    return (k == 0) ? W0 : W1;
  endfunction

  function automatic logic model_err(input ev_t e);
    return ($countones(e.size) != 1) || (e.we && e.rd) ||
           ((e.size == SZ_H) && e.addr[0]) ||
           ((e.size == SZ_W) && (e.addr[1:0] != 2'b00));
  endfunction

  // Store: write the 1, 2 or 4 addressed bytes, each taken from its own lane.
  task automatic model_store(input int k, input ev_t e);
    int nb;
    nb = (e.size == SZ_B) ? 1 : (e.size == SZ_H) ? 2 : 4;
    for (int j = 0; j < nb; j++) begin
      int b;
      b = int'(e.addr) + j;
      mem_b[k][b] = e.data[8*(b % 4) +: 8];
    end
  endtask

  function automatic logic [31:0] model_load(input int k, input logic [AW-1:0] addr);
    int w;
    w = int'(addr) & ~3;
    return {mem_b[k][w+3], mem_b[k][w+2], mem_b[k][w+1], mem_b[k][w]};
  endfunction

  task automatic compare_dut(input int k);
    logic        e_ack, e_err, e_busy;
    logic [31:0] e_data;
    logic        a_ack, a_err, a_busy;
    logic [31:0] a_data;
    e_ack = 1'b0; e_err = 1'b0; e_busy = 1'b0; e_data = 32'h0;
    foreach (ev_q[i]) begin
      if (ev_q[i].dut == k) begin
        if (ev_q[i].t_ack == cyc) begin
          e_ack = 1'b1;
          e_err = model_err(ev_q[i]);
          if (!e_err) begin
            if (ev_q[i].we) model_store(k, ev_q[i]);
            else            e_data = model_load(k, ev_q[i].addr);
          end
        end
        if (cyc > ev_q[i].t_acc && cyc <= ev_q[i].t_acc + wait_of(k)) e_busy = 1'b1;
      end
    end
    if (k == 0) begin
      a_ack = bus0.rbm_ack_o; a_err = bus0.rbm_err_o;
      a_busy = bus0.rbm_busy_o; a_data = bus0.rbm_data_o;
    end else begin
      a_ack = bus1.rbm_ack_o; a_err = bus1.rbm_err_o;
      a_busy = bus1.rbm_busy_o; a_data = bus1.rbm_data_o;
    end
    check($sformatf("d%0d_ack@%0d", k, cyc),  32'(a_ack),  32'(e_ack));
    check($sformatf("d%0d_err@%0d", k, cyc),  32'(a_err),  32'(e_err));
    check($sformatf("d%0d_busy@%0d", k, cyc), 32'(a_busy), 32'(e_busy));
    check($sformatf("d%0d_data@%0d", k, cyc), a_data, e_data);
    if (e_ack) begin
      last_exp[k]     = e_data;
      last_err_exp[k] = e_err;
    end
    if (a_ack) begin
      ack_cnt[k]++;
      last_act[k]     = a_data;
      last_err_act[k] = a_err;
    end
    for (int i = ev_q.size() - 1; i >= 0; i--) begin
      if (ev_q[i].dut == k && ev_q[i].t_ack <= cyc) ev_q.delete(i);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      compare_dut(0);
      compare_dut(1);
    end
  end

  task automatic drive(input int k, input logic [AW-1:0] a, input logic [31:0] d,
                       input logic [2:0] s, input logic we, input logic rd);
    if (k == 0) begin
      bus0.rbm_addr_i = a; bus0.rbm_data_i = d; bus0.rbm_size_i = s;
      bus0.rbm_we_i = we;  bus0.rbm_rd_i = rd;
    end else begin
      bus1.rbm_addr_i = a; bus1.rbm_data_i = d; bus1.rbm_size_i = s;
      bus1.rbm_we_i = we;  bus1.rbm_rd_i = rd;
    end
  endtask

  // Present a request; the model predicts acceptance at the first cycle the
  // slave is free. The request is held through the busy cycles with the data
  // lanes scrambled, since the slave must not sample them again. Returns in
  // the ack cycle with the request still on the bus.
  task automatic xact(input int k, input logic [AW-1:0] a, input logic [31:0] d,
                      input logic [2:0] s, input logic we, input logic rd);
    int w, t;
    w = wait_of(k);
    t = (cyc > free_c[k]) ? cyc : free_c[k];
    ev_q.push_back('{k, t, t + 1 + w, a, d, s, we, rd});
    free_c[k] = t + 1 + w;
    drive(k, a, d, s, we, rd);
    while (cyc <= t) begin
      @(posedge clk); #1;
    end
    for (int i = 0; i < w; i++) begin
      drive(k, a, ~d, s, we, rd);
      @(posedge clk); #1;
    end
  endtask

  task automatic idle(input int k, input int n);
    drive(k, '0, 32'h0, 3'b000, 1'b0, 1'b0);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic check_lit(input string name, input int k, input logic [31:0] lit);
    check({name, "_model"}, last_exp[k], lit);
    check({name, "_dut"},   last_act[k], lit);
  endtask

  initial begin
    int acks_before;
    int t;

    drive(0, '0, 32'h0, 3'b000, 1'b0, 1'b0);
    drive(1, '0, 32'h0, 3'b000, 1'b0, 1'b0);
    ack_cnt[0] = 0; ack_cnt[1] = 0;
    rst0 = 1'b1; rst1 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_d0_ack",  32'(bus0.rbm_ack_o),  32'h0);
    check("rst_d0_err",  32'(bus0.rbm_err_o),  32'h0);
    check("rst_d0_busy", 32'(bus0.rbm_busy_o), 32'h0);
    check("rst_d0_data", bus0.rbm_data_o,      32'h0);
    check("rst_d1_ack",  32'(bus1.rbm_ack_o),  32'h0);
    check("rst_d1_data", bus1.rbm_data_o,      32'h0);
    rst0 = 1'b0; rst1 = 1'b0;
    free_c[0] = cyc; free_c[1] = cyc;
    cmp_en = 1'b1;
    idle(0, 2);

    // ---- dut0: no wait states --------------------------------------------
    xact(0, 12'h010, 32'hDEADBEEF, SZ_W, 1'b1, 1'b0);
    xact(0, 12'h010, 32'h0,        SZ_W, 1'b0, 1'b1);
    idle(0, 2);
    check_lit("raw", 0, 32'hDEADBEEF);

    xact(0, 12'h010, 32'h11223344, SZ_W, 1'b1, 1'b0);
    xact(0, 12'h011, 32'h0000AB00, SZ_B, 1'b1, 1'b0);
    xact(0, 12'h010, 32'h0,        SZ_W, 1'b0, 1'b1);
    idle(0, 2);
    check_lit("byte_st", 0, 32'h1122AB44);

    xact(0, 12'h020, 32'h00000000, SZ_W, 1'b1, 1'b0);
    xact(0, 12'h022, 32'hCAFE0000, SZ_H, 1'b1, 1'b0);
    xact(0, 12'h020, 32'h0,        SZ_W, 1'b0, 1'b1);
    idle(0, 2);
    check_lit("half_st", 0, 32'hCAFE0000);

    xact(0, 12'h021, 32'h0, SZ_H, 1'b0, 1'b1);
    idle(0, 2);
    check("half_mis_err_model", 32'(last_err_exp[0]), 32'h1);
    check("half_mis_err_dut",   32'(last_err_act[0]), 32'h1);
    check_lit("half_mis_data", 0, 32'h0);

    xact(0, 12'h004, 32'h0BADF00D, SZ_W,   1'b1, 1'b0);
    xact(0, 12'h010, 32'hFFFFFFFF, 3'b011, 1'b1, 1'b0);
    xact(0, 12'h010, 32'hFFFFFFFF, SZ_W,   1'b1, 1'b1);
    xact(0, 12'h006, 32'hFFFFFFFF, SZ_W,   1'b1, 1'b0);
    idle(0, 2);
    check("word_mis_err_dut", 32'(last_err_act[0]), 32'h1);
    xact(0, 12'h010, 32'h0, SZ_W, 1'b0, 1'b1);
    idle(0, 2);
    check_lit("err_keep10", 0, 32'h1122AB44);
    xact(0, 12'h004, 32'h0, SZ_W, 1'b0, 1'b1);
    idle(0, 2);
    check_lit("err_keep04", 0, 32'h0BADF00D);

    // ---- dut1: three wait states -----------------------------------------
    xact(1, 12'h030, 32'h12345678, SZ_W, 1'b1, 1'b0);
    idle(1, 2);
    acks_before = ack_cnt[1];
    xact(1, 12'h030, 32'h0, SZ_W, 1'b0, 1'b1);
    idle(1, 4);
    check("held_single_ack", 32'(ack_cnt[1] - acks_before), 32'h1);
    check_lit("held_load", 1, 32'h12345678);

    xact(1, 12'h034, 32'hA5A55A5A, SZ_W, 1'b1, 1'b0);
    xact(1, 12'h034, 32'h0,        SZ_W, 1'b0, 1'b1);
    idle(1, 2);
    check_lit("raw_w3", 1, 32'hA5A55A5A);

    // Reset while a store sits in WAIT: the store is dropped.
    acks_before = ack_cnt[1];
    t = cyc;
    ev_q.push_back('{1, t, t + 1 + W1, 12'h030, 32'h55AA55AA, SZ_W, 1'b1, 1'b0});
    drive(1, 12'h030, 32'h55AA55AA, SZ_W, 1'b1, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst1 = 1'b1;
    for (int i = ev_q.size() - 1; i >= 0; i--) begin
      if (ev_q[i].dut == 1) ev_q.delete(i);
    end
    drive(1, '0, 32'h0, 3'b000, 1'b0, 1'b0);
    #1;
    check("mid_rst_ack",  32'(bus1.rbm_ack_o),  32'h0);
    check("mid_rst_err",  32'(bus1.rbm_err_o),  32'h0);
    check("mid_rst_busy", 32'(bus1.rbm_busy_o), 32'h0);
    check("mid_rst_data", bus1.rbm_data_o,      32'h0);
    @(posedge clk); #2;
    rst1 = 1'b0;
    free_c[1] = cyc;
    idle(1, 6);
    check("mid_rst_no_ack", 32'(ack_cnt[1] - acks_before), 32'h0);
    xact(1, 12'h030, 32'h0, SZ_W, 1'b0, 1'b1);
    idle(1, 2);
    check_lit("rst_drop", 1, 32'h12345678);

    idle(0, 2);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #100000;
    n_err++;
    $display("FAIL watchdog: simulation did not complete, got timeout, want finish");
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule : tb_rbm_sram_slave
